// File: rtl/xdfil_req_arb_pkg.sv
// Shared types and constants for the xdfil DMA request arbiter (package xdfil_pkg).
package xdfil_pkg;

    localparam int XDFIL_REQ_W        = 43;
    localparam int XDFIL_REQ_LAST_BIT = 42;

    typedef logic [XDFIL_REQ_W-1:0] xdfil_dma_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCK_S0 = 2'd1,
        LOCK_S1 = 2'd2
    } xdfil_arb_state_e;

endpackage

// File: rtl/xdfil_req_arb_if.sv
// Request stream bundle: beat data, valid, and backpressure (stall).
// The master drives the beat; the slave drives stall back.
interface xdfil_req_arb_if #(
    parameter int REQ_W = 43
) ();
    logic [REQ_W-1:0] req_data;
    logic             req_valid;
    logic             req_stall;

    modport master (output req_data, output req_valid, input  req_stall);
    modport slave  (input  req_data, input  req_valid, output req_stall);
endinterface

// File: rtl/xdfil_req_arb_oreg.sv
// Registered output stage: loads a new beat on accept, holds it under stall,
// and drops valid once the downstream takes the beat with nothing new behind it.
module xdfil_req_arb_oreg #(
    parameter int REQ_W = 43
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [REQ_W-1:0] i_data,
    input  logic             i_take,
    output logic             o_valid,
    output logic [REQ_W-1:0] o_data
);

    logic             r_valid;
    logic [REQ_W-1:0] r_data;

    // Valid/data register; a load in the same cycle as a take replaces the beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_take) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/xdfil_req_arb.sv
// Two-input round-robin request arbiter with burst locking, a registered
// output stage and a burst-length watchdog raising a sticky error.
// Optional feature: define XDFIL_REQ_ARB_WEIGHT_EN for weighted round-robin
// (S0_WEIGHT / S1_WEIGHT consecutive bursts for the priority holder).
module xdfil_req_arb
    import xdfil_pkg::*;
#(
    parameter int REQ_W     = 43,
    parameter int MAX_BURST = 16,
    parameter int S0_WEIGHT = 2,
    parameter int S1_WEIGHT = 1
) (
    input  logic             xdfil_clk,
    input  logic             xdfil_rst_n,
    xdfil_req_arb_if.slave   s0_req,
    xdfil_req_arb_if.slave   s1_req,
    xdfil_req_arb_if.master  xdfil2dma_req,
    input  logic             arb_err_clr,
    output logic             arb_err_intr
);

    // Counters are 8 bits (beats) and 4 bits (weights); reject configurations they cannot hold.
    if (MAX_BURST < 1 || MAX_BURST > 255 ||
        S0_WEIGHT < 1 || S0_WEIGHT > 15 ||
        S1_WEIGHT < 1 || S1_WEIGHT > 15) begin : g_param_chk
        $error("xdfil_req_arb: parameter out of range");
    end

    xdfil_arb_state_e r_state, w_state_nxt;
    logic             r_rr_ptr, w_rr_nxt;
    logic [7:0]       r_beat_cnt, w_beat_nxt;
    logic             r_err;

    logic             w_out_valid;
    logic [REQ_W-1:0] w_out_data;
    logic             w_out_ready;
    logic             w_elig0, w_elig1;
    logic             w_acc0, w_acc1, w_accept;
    logic             w_win;
    logic [REQ_W-1:0] w_acc_data;
    logic             w_last;
    logic [7:0]       w_cnt_inc;
    logic             w_overrun;
    logic             w_burst_end;

    assign w_out_ready = !w_out_valid || !xdfil2dma_req.req_stall;

    // Pick the eligible side: locked side during a burst, otherwise rr_ptr on contention.
    always_comb begin
        w_elig0 = 1'b0;
        w_elig1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (s0_req.req_valid && s1_req.req_valid) begin
                    if (r_rr_ptr) w_elig1 = 1'b1;
                    else          w_elig0 = 1'b1;
                end else if (s0_req.req_valid) begin
                    w_elig0 = 1'b1;
                end else if (s1_req.req_valid) begin
                    w_elig1 = 1'b1;
                end
            end
            LOCK_S0: w_elig0 = 1'b1;
            LOCK_S1: w_elig1 = 1'b1;
            default: begin
                w_elig0 = 1'b0;
                w_elig1 = 1'b0;
            end
        endcase
    end

    // Sources are held off during reset so nothing is issued into a dead pipeline.
    assign s0_req.req_stall = !xdfil_rst_n || !(w_elig0 && w_out_ready);
    assign s1_req.req_stall = !xdfil_rst_n || !(w_elig1 && w_out_ready);

    assign w_acc0     = w_elig0 && s0_req.req_valid && w_out_ready;
    assign w_acc1     = w_elig1 && s1_req.req_valid && w_out_ready;
    assign w_accept   = w_acc0 || w_acc1;
    assign w_win      = w_acc1;
    assign w_acc_data = w_acc1 ? s1_req.req_data : s0_req.req_data;
    assign w_last     = w_acc_data[REQ_W-1];

    // The first beat of a burst is accepted in IDLE and counts as beat 1.
    assign w_cnt_inc   = (r_state == IDLE) ? 8'd1 : r_beat_cnt + 8'd1;
    assign w_overrun   = w_accept && !w_last && (w_cnt_inc >= 8'(MAX_BURST));
    assign w_burst_end = w_accept && (w_last || w_overrun);

    // Next state and beat count: lock on an open burst, release on last beat or watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        if (w_burst_end) begin
            w_state_nxt = IDLE;
            w_beat_nxt  = 8'd0;
        end else if (w_accept) begin
            w_state_nxt = w_win ? LOCK_S1 : LOCK_S0;
            w_beat_nxt  = w_cnt_inc;
        end
    end

`ifdef XDFIL_REQ_ARB_WEIGHT_EN
    logic [3:0] r_wt_cnt, w_wt_nxt;
    logic [3:0] w_wt_lim;

    assign w_wt_lim = r_rr_ptr ? 4'(S1_WEIGHT) : 4'(S0_WEIGHT);

    // Priority holder keeps priority for its weight in bursts; a non-priority winner changes nothing.
    always_comb begin
        w_rr_nxt = r_rr_ptr;
        w_wt_nxt = r_wt_cnt;
        if (w_burst_end && (w_win == r_rr_ptr)) begin
            if (r_wt_cnt + 4'd1 >= w_wt_lim) begin
                w_rr_nxt = !r_rr_ptr;
                w_wt_nxt = 4'd0;
            end else begin
                w_wt_nxt = r_wt_cnt + 4'd1;
            end
        end
    end

    // Weight counter register.
    always_ff @(posedge xdfil_clk or negedge xdfil_rst_n) begin
        if (!xdfil_rst_n) r_wt_cnt <= 4'd0;
        else              r_wt_cnt <= w_wt_nxt;
    end
`else
    // Strict alternation: priority moves to the other side after every burst.
    always_comb begin
        w_rr_nxt = r_rr_ptr;
        if (w_burst_end) w_rr_nxt = !w_win;
    end
`endif

    // Arbiter state, priority pointer, beat counter and sticky error (set beats clear).
    always_ff @(posedge xdfil_clk or negedge xdfil_rst_n) begin
        if (!xdfil_rst_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= 1'b0;
            r_beat_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_err      <= (r_err && !arb_err_clr) || w_overrun;
        end
    end

    assign arb_err_intr = r_err;

    xdfil_req_arb_oreg #(
        .REQ_W (REQ_W)
    ) u_oreg (
        .i_clk   (xdfil_clk),
        .i_rst_n (xdfil_rst_n),
        .i_load  (w_accept),
        .i_data  (w_acc_data),
        .i_take  (w_out_valid && !xdfil2dma_req.req_stall),
        .o_valid (w_out_valid),
        .o_data  (w_out_data)
    );

    assign xdfil2dma_req.req_valid = w_out_valid;
    assign xdfil2dma_req.req_data  = w_out_data;

endmodule

// File: tb/tb_xdfil_req_arb.sv
// Scoreboard bench for xdfil_req_arb: per-side source drivers, an expected-beat
// queue filled by the directed tests, and an output monitor that pops and compares.
module tb_xdfil_req_arb;
    import xdfil_pkg::*;

    localparam int REQ_W = XDFIL_REQ_W;

    logic clk = 1'b0;
    logic rst_n;
    logic err_clr;
    logic err_intr;

    xdfil_req_arb_if #(.REQ_W(REQ_W)) s0_if ();
    xdfil_req_arb_if #(.REQ_W(REQ_W)) s1_if ();
    xdfil_req_arb_if #(.REQ_W(REQ_W)) dma_if ();

    xdfil_req_arb #(
        .REQ_W     (REQ_W),
        .MAX_BURST (16),
        .S0_WEIGHT (2),
        .S1_WEIGHT (1)
    ) dut (
        .xdfil_clk     (clk),
        .xdfil_rst_n   (rst_n),
        .s0_req        (s0_if),
        .s1_req        (s1_if),
        .xdfil2dma_req (dma_if),
        .arb_err_clr   (err_clr),
        .arb_err_intr  (err_intr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rx_cnt  = 0;
    int rx_cyc[$];
    xdfil_dma_req_t q0[$];
    xdfil_dma_req_t q1[$];
    xdfil_dma_req_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic xdfil_dma_req_t beat(input logic [1:0] side, input int idx, input logic last);
        xdfil_dma_req_t b;
        b = '0;
        b[XDFIL_REQ_LAST_BIT] = last;
        b[41:40] = side;
        b[31:0]  = idx[31:0];
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // s0 source: advance only after a beat was taken on the preceding edge
    initial begin
        logic took;
        s0_if.req_valid = 1'b0;
        s0_if.req_data  = '0;
        forever begin
            @(negedge clk);
            took = s0_if.req_valid && !s0_if.req_stall;
            @(posedge clk);
            #1;
            if (took && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                s0_if.req_valid = 1'b1;
                s0_if.req_data  = q0[0];
            end else begin
                s0_if.req_valid = 1'b0;
                s0_if.req_data  = '0;
            end
        end
    end

    // s1 source
    initial begin
        logic took;
        s1_if.req_valid = 1'b0;
        s1_if.req_data  = '0;
        forever begin
            @(negedge clk);
            took = s1_if.req_valid && !s1_if.req_stall;
            @(posedge clk);
            #1;
            if (took && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                s1_if.req_valid = 1'b1;
                s1_if.req_data  = q1[0];
            end else begin
                s1_if.req_valid = 1'b0;
                s1_if.req_data  = '0;
            end
        end
    end

    // Output monitor: every beat the DMA takes is compared against the scoreboard
    initial begin
        xdfil_dma_req_t e;
        forever begin
            @(negedge clk);
            if (rst_n && dma_if.req_valid && !dma_if.req_stall) begin
                rx_cnt++;
                rx_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", dma_if.req_data, '1);
                end else begin
                    e = exp_q.pop_front();
                    check("dma_beat", dma_if.req_data, e);
                end
            end
        end
    end

    task automatic wait_drain(input int max_cyc, input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0 || dma_if.req_valid) && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, (q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !dma_if.req_valid), 1);
    endtask

    task automatic wait_rx(input int target, input int max_cyc, input string name);
        int n = 0;
        while (rx_cnt < target && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, rx_cnt >= target, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n_s0;
        xdfil_dma_req_t held;

        rst_n   = 1'b0;
        err_clr = 1'b0;
        dma_if.req_stall = 1'b0;

        // Reset: sources valid but stalled, outputs cleared
        q0.push_back(beat(2'd1, 0, 1'b1));
        q1.push_back(beat(2'd2, 0, 1'b1));
        exp_q.push_back(beat(2'd1, 0, 1'b1));
        exp_q.push_back(beat(2'd2, 0, 1'b1));
        repeat (3) @(negedge clk);
        check("rst_out_valid", dma_if.req_valid, 0);
        check("rst_out_data", dma_if.req_data, 0);
        check("rst_err", err_intr, 0);
        check("rst_s0_stall", s0_if.req_stall, 1);
        check("rst_s1_stall", s1_if.req_stall, 1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_drain(20, "drain_rst");

        // Contention with single-beat bursts: alternate, one beat per cycle
        base = rx_cyc.size();
        q0.push_back(beat(2'd1, 10, 1'b1)); q0.push_back(beat(2'd1, 11, 1'b1));
        q1.push_back(beat(2'd2, 10, 1'b1)); q1.push_back(beat(2'd2, 11, 1'b1));
        exp_q.push_back(beat(2'd1, 10, 1'b1)); exp_q.push_back(beat(2'd2, 10, 1'b1));
        exp_q.push_back(beat(2'd1, 11, 1'b1)); exp_q.push_back(beat(2'd2, 11, 1'b1));
        wait_drain(20, "drain_alt");
        check("alt_count", rx_cyc.size() - base, 4);
        if (rx_cyc.size() >= base + 4)
            check("alt_back_to_back", rx_cyc[base+3] - rx_cyc[base], 3);

        // Burst lock: s0 4-beat burst, s1 held off, s1 follows immediately
        base = rx_cyc.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(beat(2'd1, 20 + i, i == 3));
            exp_q.push_back(beat(2'd1, 20 + i, i == 3));
        end
        q1.push_back(beat(2'd2, 20, 1'b1));
        exp_q.push_back(beat(2'd2, 20, 1'b1));
        n_s0 = 0;
        for (int i = 0; i < 20 && n_s0 < 4; i++) begin
            @(negedge clk);
            if (s0_if.req_valid && !s0_if.req_stall) begin
                n_s0++;
                check("lock_s1_stall", s1_if.req_stall, 1);
            end
        end
        check("lock_s0_beats", n_s0, 4);
        wait_drain(20, "drain_lock");
        if (rx_cyc.size() >= base + 5)
            check("lock_s1_follows", rx_cyc[base+4] - rx_cyc[base+3], 1);
        else
            check("lock_count", rx_cyc.size() - base, 5);

        // Backpressure: DMA stalls 3 cycles mid-burst
        base = rx_cnt;
        for (int i = 0; i < 5; i++) begin
            q0.push_back(beat(2'd1, 30 + i, i == 4));
            exp_q.push_back(beat(2'd1, 30 + i, i == 4));
        end
        wait_rx(base + 2, 20, "bp_wait");
        @(posedge clk);
        #1;
        dma_if.req_stall = 1'b1;
        held = dma_if.req_data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", dma_if.req_valid, 1);
            check("bp_hold_data", dma_if.req_data, held);
            check("bp_s0_stall", s0_if.req_stall, 1);
            check("bp_s1_stall", s1_if.req_stall, 1);
        end
        @(posedge clk);
        #1;
        dma_if.req_stall = 1'b0;
        wait_drain(20, "drain_bp");
        check("bp_count", rx_cnt - base, 5);

        // Watchdog: s1 20 beats without last, forced release after 16, s0 next
        base = rx_cnt;
        for (int i = 0; i < 20; i++) q1.push_back(beat(2'd2, 40 + i, 1'b0));
        for (int i = 0; i < 16; i++) exp_q.push_back(beat(2'd2, 40 + i, 1'b0));
        wait_rx(base + 3, 20, "wd_wait3");
        check("wd_err_early", err_intr, 0);
        q0.push_back(beat(2'd1, 40, 1'b1));
        exp_q.push_back(beat(2'd1, 40, 1'b1));
        for (int i = 16; i < 20; i++) exp_q.push_back(beat(2'd2, 40 + i, 1'b0));
        wait_rx(base + 16, 30, "wd_wait16");
        check("wd_err_set", err_intr, 1);
        wait_drain(40, "drain_wd");
        check("wd_err_sticky", err_intr, 1);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        check("wd_err_clr", err_intr, 0);

        // Reset mid-burst: end s1 lock, move priority to s1, then reset during s0 beat 2
        q1.push_back(beat(2'd2, 100, 1'b1)); exp_q.push_back(beat(2'd2, 100, 1'b1));
        wait_drain(20, "drain_unlock");
        q0.push_back(beat(2'd1, 101, 1'b1)); exp_q.push_back(beat(2'd1, 101, 1'b1));
        wait_drain(20, "drain_prio");
        base = rx_cnt;
        q0.push_back(beat(2'd1, 102, 1'b0));
        q0.push_back(beat(2'd1, 103, 1'b0));
        q0.push_back(beat(2'd1, 104, 1'b1));
        exp_q.push_back(beat(2'd1, 102, 1'b0));
        wait_rx(base + 1, 20, "mr_wait");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", dma_if.req_valid, 0);
        check("mr_out_data", dma_if.req_data, 0);
        check("mr_s0_stall", s0_if.req_stall, 1);
        q0.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q0.push_back(beat(2'd1, 105, 1'b1)); q1.push_back(beat(2'd2, 105, 1'b1));
        exp_q.push_back(beat(2'd1, 105, 1'b1)); exp_q.push_back(beat(2'd2, 105, 1'b1));
        wait_drain(20, "drain_mr");

        // Fresh reset, then continuous contention with single beats
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) q0.push_back(beat(2'd1, 110 + i, 1'b1));
        for (int i = 0; i < 2; i++) q1.push_back(beat(2'd2, 110 + i, 1'b1));
`ifdef XDFIL_REQ_ARB_WEIGHT_EN
        exp_q.push_back(beat(2'd1, 110, 1'b1)); exp_q.push_back(beat(2'd1, 111, 1'b1));
        exp_q.push_back(beat(2'd2, 110, 1'b1)); exp_q.push_back(beat(2'd1, 112, 1'b1));
        exp_q.push_back(beat(2'd1, 113, 1'b1)); exp_q.push_back(beat(2'd2, 111, 1'b1));
`else
        exp_q.push_back(beat(2'd1, 110, 1'b1)); exp_q.push_back(beat(2'd2, 110, 1'b1));
        exp_q.push_back(beat(2'd1, 111, 1'b1)); exp_q.push_back(beat(2'd2, 111, 1'b1));
        exp_q.push_back(beat(2'd1, 112, 1'b1)); exp_q.push_back(beat(2'd1, 113, 1'b1));
`endif
        wait_drain(30, "drain_weight");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
